board_update_ctrl: RTL

//  Owns the 256-bit board state (64 cells x 4-bit piece code) that feeds the checkerboard renderer.

---
 rtl/board_pkg.sv | 24 ++
 rtl/rr_arbiter2.sv | 21 ++
 rtl/board_update_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/board_pkg.sv
// Shared constants and types for the board state controller.
// Cell geometry, FSM states and grant encoding live here.
package board_pkg;

    localparam int CELLS  = 64;
    localparam int CELL_W = 4;
    localparam int BUF_W  = CELLS * CELL_W;
    localparam int IDX_W  = 6;

    typedef enum logic {
        IDLE = 1'b0,
        SWAP = 1'b1
    } state_t;

    localparam logic [CELL_W-1:0] EMPTY = 4'h0;

    localparam logic GNT_A = 1'b0;
    localparam logic GNT_B = 1'b1;

    function automatic logic [7:0] cell_lsb(input logic [IDX_W-1:0] idx);
        return {idx, 2'b00};
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; on a tie the requester that was
// not granted last wins. Output is one-hot or zero.
module rr_arbiter2
    import board_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == GNT_B) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/board_update_ctrl.sv
// Double-buffered board state: requesters write a shadow copy which
// is copied to the renderer-facing front buffer only on vblank.
module board_update_ctrl
    import board_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             vblank,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [IDX_W-1:0] a_idx,
    input  logic [CELL_W-1:0] a_code,
    input  logic             a_clr,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [IDX_W-1:0] b_idx,
    input  logic [CELL_W-1:0] b_code,
    input  logic             b_clr,
    output logic [BUF_W-1:0] board_buf,
    output logic             dirty,
    output logic             swap_pulse
);

    state_t             r_state;
    state_t             w_next;
    logic               r_vblank_q;
    logic               r_swap_pend;
    logic               r_last;
    logic               r_dirty;
    logic               r_pulse;
    logic [BUF_W-1:0]   r_shadow;
    logic [BUF_W-1:0]   r_front;

    logic               w_rise;
    logic               w_pend_go;
    logic               w_grant_en;
    logic [1:0]         w_gnt;
    logic               w_any;
    logic               w_sel_b;
    logic [IDX_W-1:0]   w_idx;
    logic [CELL_W-1:0]  w_code;
    logic               w_clr;

    assign w_rise    = vblank & ~r_vblank_q;
    // A pending swap is only honoured while vblank is still high.
    assign w_pend_go = r_swap_pend & vblank;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_grant_en = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_pend_go) begin
                    w_next = SWAP;
                end else begin
                    w_grant_en = reset_n;
                end
            end
            SWAP: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    rr_arbiter2 u_arb (
        .req  ({b_valid, a_valid} & {2{w_grant_en}}),
        .last (r_last),
        .gnt  (w_gnt)
    );

    assign a_ready = w_gnt[0];
    assign b_ready = w_gnt[1];
    assign w_any   = |w_gnt;
    assign w_sel_b = w_gnt[1];
    assign w_idx   = w_sel_b ? b_idx  : a_idx;
    assign w_code  = w_sel_b ? b_code : a_code;
    assign w_clr   = w_sel_b ? b_clr  : a_clr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shadow <= '0;
        end else if (w_any) begin
            if (w_clr) begin
                r_shadow <= {CELLS{EMPTY}};
            end else begin
                r_shadow[cell_lsb(w_idx) +: CELL_W] <= w_code;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_front     <= '0;
            r_dirty     <= 1'b0;
            r_pulse     <= 1'b0;
            r_vblank_q  <= 1'b0;
            r_swap_pend <= 1'b0;
            r_last      <= GNT_B;
        end else begin
            r_vblank_q <= vblank;
            r_pulse    <= (r_state == SWAP);
            if (r_state == SWAP) begin
                r_front     <= r_shadow;
                r_dirty     <= 1'b0;
                r_swap_pend <= 1'b0;
            end else begin
                if (w_any) begin
                    r_dirty <= 1'b1;
                    r_last  <= w_sel_b;
                end
                // A grant on the rise edge still makes this frame's swap.
                if (w_rise && (r_dirty || w_any)) begin
                    r_swap_pend <= 1'b1;
                end else if (!vblank) begin
                    r_swap_pend <= 1'b0;
                end
            end
        end
    end

    assign board_buf  = r_front;
    assign dirty      = r_dirty;
    assign swap_pulse = r_pulse;

endmodule
